vga_timing_gen: RTL and testbench

//  Parametrised VGA raster timing generator; successor to the fixed 640x480 controller.
//  - Derives a pixel-enable strobe from the system clock and runs h/v raster counters.
//  - Drives x/y, line/frame strobes and sync/blank to the monitor/DAC.
//  - Delays sync/blank by a programmable number of pixel ticks to match the renderer pipeline.

---
 rtl/vga_pkg.sv | 35 +++
 rtl/vga_delay_line.sv | 40 ++++
 rtl/vga_timing_gen.sv | 166 ++++++++++++++++
 tb/tb_vga_timing_gen.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing types, the stock 640x480 mode and raster-size helpers.
package vga_pkg;

    typedef struct packed {
        int unsigned hactive;
        int unsigned hfp;
        int unsigned hsyn;
        int unsigned hbp;
        int unsigned vactive;
        int unsigned vfp;
        int unsigned vsyn;
        int unsigned vbp;
    } timing_t;

    // Raw raster flags that travel together through the render-alignment delay.
    typedef struct packed {
        logic hs;
        logic vs;
        logic active;
    } raster_t;

    localparam timing_t VGA_640X480 = '{
        hactive: 640, hfp: 16, hsyn: 96, hbp: 48,
        vactive: 480, vfp: 11, vsyn: 2,  vbp: 32
    };

    function automatic int unsigned h_max(timing_t t);
        return t.hactive + t.hfp + t.hsyn + t.hbp;
    endfunction

    function automatic int unsigned v_max(timing_t t);
        return t.vactive + t.vfp + t.vsyn + t.vbp;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register; every stage resets to INIT. DEPTH=0 is a wire.
module vga_delay_line #(
    parameter int          W     = 1,
    parameter int          DEPTH = 1,
    parameter logic [W-1:0] INIT = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    if (DEPTH == 0) begin : g_bypass
        assign q = d;
    end else begin : g_stages
        logic [W-1:0] stage_q [DEPTH];
        logic [W-1:0] stage_d [DEPTH];

        always_comb begin
            for (int i = 0; i < DEPTH; i++) stage_d[i] = stage_q[i];
            if (en) begin
                stage_d[0] = d;
                for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
            end
        end

        // NOTE: these stages are reset, unlike a plain data memory, so sync and
        // blank sit at their inactive level until real raster data has shifted through.
        always_ff @(posedge clk) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (reset) stage_q[i] <= INIT;
                else       stage_q[i] <= stage_d[i];
            end
        end

        assign q = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel-tick divider and sync/blank delay.
// Optional completed-frame counter port enabled by defining VGA_FRAME_CNT_EN.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned DIV       = 2,
    parameter int unsigned HACTIVE   = VGA_640X480.hactive,
    parameter int unsigned HFP       = VGA_640X480.hfp,
    parameter int unsigned HSYN      = VGA_640X480.hsyn,
    parameter int unsigned HBP       = VGA_640X480.hbp,
    parameter int unsigned VACTIVE   = VGA_640X480.vactive,
    parameter int unsigned VFP       = VGA_640X480.vfp,
    parameter int unsigned VSYN      = VGA_640X480.vsyn,
    parameter int unsigned VBP       = VGA_640X480.vbp,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0,
    parameter int unsigned PIPE_DLY  = 0,
    parameter int unsigned CW        = 10,
    parameter int unsigned FCW       = 16
) (
    input  logic          clk,
    input  logic          reset,
    output logic          pix_en,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          active,
    output logic          line_start,
    output logic          frame_start,
    output logic          hsync,
    output logic          vsync,
    output logic          sync_b,
    output logic          blank_b
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [FCW-1:0] frame_cnt
`endif
);

    localparam timing_t TIM = '{
        hactive: HACTIVE, hfp: HFP, hsyn: HSYN, hbp: HBP,
        vactive: VACTIVE, vfp: VFP, vsyn: VSYN, vbp: VBP
    };
    localparam int unsigned HMAX     = h_max(TIM);
    localparam int unsigned VMAX     = v_max(TIM);
    localparam int unsigned HS_START = HACTIVE + HFP;
    localparam int unsigned VS_START = VACTIVE + VFP;
    localparam int          DW       = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [CW-1:0] X_LAST   = CW'(HMAX - 1);
    localparam logic [CW-1:0] Y_LAST   = CW'(VMAX - 1);
    localparam raster_t       RAW_IDLE = '{hs: ~HSYNC_POL, vs: ~VSYNC_POL, active: 1'b0};

    if (DIV < 1) begin : g_div_check
        $error("vga_timing_gen: DIV must be at least 1");
    end
    if (HMAX > 2**CW || VMAX > 2**CW) begin : g_cw_check
        $error("vga_timing_gen: HMAX or VMAX does not fit in CW bits");
    end
    if (PIPE_DLY > 15) begin : g_dly_check
        $error("vga_timing_gen: PIPE_DLY must be 0..15");
    end
    if (FCW < 1) begin : g_fcw_check
        $error("vga_timing_gen: FCW must be at least 1");
    end

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic          pix_en_q, pix_en_d;
    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;
    raster_t       raw_q, raw_d;
    raster_t       dly;

    // x/y step on the clk that ends a pix_en pulse, so the pulse itself shows the
    // position it belongs to; strobes and raw flags are derived from the next x/y.
    always_comb begin
        // NOTE: every _d gets its hold value first, so no path through this block infers a latch.
        div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
        pix_en_d  = (div_cnt_q == DIV_LAST);
        x_d       = x_q;
        y_d       = y_q;
        if (pix_en_q) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
        line_start_d  = pix_en_d && (x_d == '0);
        frame_start_d = line_start_d && (y_d == '0);
        raw_d.active  = (32'(x_d) < HACTIVE) && (32'(y_d) < VACTIVE);
        raw_d.hs      = (32'(x_d) >= HS_START && 32'(x_d) < HS_START + HSYN) ? HSYNC_POL : ~HSYNC_POL;
        raw_d.vs      = (32'(y_d) >= VS_START && 32'(y_d) < VS_START + VSYN) ? VSYNC_POL : ~VSYNC_POL;
    end

    // NOTE: sequential state is written with <= only; next-state math above uses = .
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q     <= '0;
            pix_en_q      <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            raw_q         <= RAW_IDLE;
        end else begin
            div_cnt_q     <= div_cnt_d;
            pix_en_q      <= pix_en_d;
            x_q           <= x_d;
            y_q           <= y_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            raw_q         <= raw_d;
        end
    end

    vga_delay_line #(
        .W     ($bits(raster_t)),
        .DEPTH (PIPE_DLY),
        .INIT  (RAW_IDLE)
    ) u_dly (
        .clk   (clk),
        .reset (reset),
        .en    (pix_en_q),
        .d     (raw_q),
        .q     (dly)
    );

`ifdef VGA_FRAME_CNT_EN
    logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
    logic           seen_first_q, seen_first_d;

    // The first frame after reset is the one in progress, not a completed one.
    always_comb begin
        seen_first_d = seen_first_q | frame_start_d;
        frame_cnt_d  = (frame_start_d && seen_first_q) ? frame_cnt_q + 1'b1 : frame_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_q  <= '0;
            seen_first_q <= 1'b0;
        end else begin
            frame_cnt_q  <= frame_cnt_d;
            seen_first_q <= seen_first_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

    assign pix_en      = pix_en_q;
    assign x           = x_q;
    assign y           = y_q;
    assign active      = raw_q.active;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign hsync       = dly.hs;
    assign vsync       = dly.vs;
    assign blank_b     = dly.active;
    assign sync_b      = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three configurations checked against a cycle-count model,
// a position table, and hand sequences for reset, line period, wrap and frame count.
module tb_vga_timing_gen;

    typedef struct {
        int div, ha, hfp, hs, hbp, va, vfp, vs, vbp, dly, fcw;
        bit hpol, vpol;
    } cfg_t;

    typedef struct packed {
        logic        pix_en;
        logic [15:0] x;
        logic [15:0] y;
        logic        active, line_start, frame_start, hsync, vsync, sync_b, blank_b;
        logic [15:0] frame_cnt;
    } obs_t;

    typedef struct {
        int   inst;
        int   x;
        int   y;
        logic hs, vs, blank;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cyc = 0;
    int   checks = 0;
    int   errors = 0;
    cfg_t cfgs[3];
    vec_t vecs[$];

    logic       def_pe, def_act, def_ls, def_fs, def_hs, def_vs, def_sb, def_bl;
    logic [9:0] def_x, def_y;
    logic       dly_pe, dly_act, dly_ls, dly_fs, dly_hs, dly_vs, dly_sb, dly_bl;
    logic [9:0] dly_x, dly_y;
    logic       tny_pe, tny_act, tny_ls, tny_fs, tny_hs, tny_vs, tny_sb, tny_bl;
    logic [3:0] tny_x, tny_y;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0] def_fc, dly_fc;
    logic [3:0]  tny_fc;
`endif

    always #5 clk = ~clk;

    // Cycles since reset released, as the DUT samples it.
    always @(posedge clk) n_cyc <= reset ? 0 : n_cyc + 1;

    vga_timing_gen u_def (
        .clk(clk), .reset(reset), .pix_en(def_pe), .x(def_x), .y(def_y), .active(def_act),
        .line_start(def_ls), .frame_start(def_fs), .hsync(def_hs), .vsync(def_vs),
        .sync_b(def_sb), .blank_b(def_bl)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(def_fc)
`endif
    );

    vga_timing_gen #(.PIPE_DLY(3)) u_dly (
        .clk(clk), .reset(reset), .pix_en(dly_pe), .x(dly_x), .y(dly_y), .active(dly_act),
        .line_start(dly_ls), .frame_start(dly_fs), .hsync(dly_hs), .vsync(dly_vs),
        .sync_b(dly_sb), .blank_b(dly_bl)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(dly_fc)
`endif
    );

    vga_timing_gen #(
        .DIV(1), .HACTIVE(8), .HFP(1), .HSYN(2), .HBP(1),
        .VACTIVE(4), .VFP(1), .VSYN(1), .VBP(1),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .PIPE_DLY(0), .CW(4), .FCW(4)
    ) u_tny (
        .clk(clk), .reset(reset), .pix_en(tny_pe), .x(tny_x), .y(tny_y), .active(tny_act),
        .line_start(tny_ls), .frame_start(tny_fs), .hsync(tny_hs), .vsync(tny_vs),
        .sync_b(tny_sb), .blank_b(tny_bl)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(tny_fc)
`endif
    );

    // Expected outputs from the number of clocks since reset release.
    function automatic obs_t model(cfg_t c, int n);
        int hmax, vmax, p, k, f, q, qx, qy, px, py;
        obs_t o;
        hmax = c.ha + c.hfp + c.hs + c.hbp;
        vmax = c.va + c.vfp + c.vs + c.vbp;
        o = '0;
        o.hsync = ~c.hpol;
        o.vsync = ~c.vpol;
        if (n > 0) begin
            p  = (n - 1) / c.div;
            k  = n / c.div;
            px = p % hmax;
            py = (p / hmax) % vmax;
            o.pix_en      = (n % c.div) == 0;
            o.x           = 16'(px);
            o.y           = 16'(py);
            o.active      = (px < c.ha) && (py < c.va);
            o.line_start  = o.pix_en && px == 0;
            o.frame_start = o.line_start && py == 0;
            if (p >= c.dly) begin
                q  = p - c.dly;
                qx = q % hmax;
                qy = (q / hmax) % vmax;
                o.blank_b = (qx < c.ha) && (qy < c.va);
                o.hsync   = (qx >= c.ha + c.hfp && qx < c.ha + c.hfp + c.hs) ? c.hpol : ~c.hpol;
                o.vsync   = (qy >= c.va + c.vfp && qy < c.va + c.vfp + c.vs) ? c.vpol : ~c.vpol;
            end
            f = (k == 0) ? 0 : (k - 1) / (hmax * vmax) + 1;
`ifdef VGA_FRAME_CNT_EN
            o.frame_cnt = (f == 0) ? 16'd0 : 16'((f - 1) % (1 << c.fcw));
`else
            o.frame_cnt = 16'(f & 0);
`endif
        end
        return o;
    endfunction

    function automatic obs_t get_obs(int inst);
        obs_t o;
        o = '0;
        case (inst)
            0: o = '{def_pe, 16'(def_x), 16'(def_y), def_act, def_ls, def_fs, def_hs, def_vs, def_sb, def_bl, 16'd0};
            1: o = '{dly_pe, 16'(dly_x), 16'(dly_y), dly_act, dly_ls, dly_fs, dly_hs, dly_vs, dly_sb, dly_bl, 16'd0};
            default: o = '{tny_pe, 16'(tny_x), 16'(tny_y), tny_act, tny_ls, tny_fs, tny_hs, tny_vs, tny_sb, tny_bl, 16'd0};
        endcase
`ifdef VGA_FRAME_CNT_EN
        case (inst)
            0: o.frame_cnt = def_fc;
            1: o.frame_cnt = dly_fc;
            default: o.frame_cnt = 16'(tny_fc);
        endcase
`endif
        return o;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT event", name);
    endtask

    // One clock; every configuration is compared with the model at the falling edge.
    task automatic step();
        obs_t a, e;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            a = get_obs(i);
            e = model(cfgs[i], n_cyc);
            check($sformatf("model_inst%0d_n%0d", i, n_cyc), 64'(a), 64'(e));
        end
    endtask

    function automatic void add_vec(int inst, int x, int y, logic hs, logic vs, logic bl);
        vec_t v;
        v = '{inst, x, y, hs, vs, bl};
        vecs.push_back(v);
    endfunction

    initial begin
        obs_t o;
        bit   found;
        int   cnt;

        cfgs[0] = '{div: 2, ha: 640, hfp: 16, hs: 96, hbp: 48, va: 480, vfp: 11, vs: 2, vbp: 32,
                    dly: 0, fcw: 16, hpol: 1'b0, vpol: 1'b0};
        cfgs[1] = cfgs[0];
        cfgs[1].dly = 3;
        cfgs[2] = '{div: 1, ha: 8, hfp: 1, hs: 2, hbp: 1, va: 4, vfp: 1, vs: 1, vbp: 1,
                    dly: 0, fcw: 4, hpol: 1'b1, vpol: 1'b0};

        // inst, x, y (-1 = any line), hsync, vsync, blank_b
        add_vec(0, 639, -1, 1, 1, 1);  add_vec(0, 640, -1, 1, 1, 0);
        add_vec(0, 655, -1, 1, 1, 0);  add_vec(0, 656, -1, 0, 1, 0);
        add_vec(0, 751, -1, 0, 1, 0);  add_vec(0, 752, -1, 1, 1, 0);
        add_vec(0, 799, -1, 1, 1, 0);  add_vec(0, 0,   -1, 1, 1, 1);
        add_vec(1, 642, -1, 1, 1, 1);  add_vec(1, 643, -1, 1, 1, 0);
        add_vec(1, 658, -1, 1, 1, 0);  add_vec(1, 659, -1, 0, 1, 0);
        add_vec(1, 754, -1, 0, 1, 0);  add_vec(1, 755, -1, 1, 1, 0);
        add_vec(1, 2,   -1, 1, 1, 0);  add_vec(1, 3,   -1, 1, 1, 1);
        add_vec(2, 8,  0, 0, 1, 0);    add_vec(2, 9,  0, 1, 1, 0);
        add_vec(2, 10, 2, 1, 1, 0);    add_vec(2, 11, 0, 0, 1, 0);
        add_vec(2, 7,  3, 0, 1, 1);    add_vec(2, 0,  4, 0, 1, 0);
        add_vec(2, 3,  5, 0, 0, 0);    add_vec(2, 3,  6, 0, 1, 0);
        add_vec(2, 0,  0, 0, 1, 1);

        // Reset state
        reset = 1'b1;
        repeat (3) step();
        check("reset_def", {def_x, def_y, def_pe, def_act, def_ls, def_fs, def_hs, def_vs, def_sb, def_bl},
              {10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        check("reset_tiny", {tny_x, tny_y, tny_pe, tny_act, tny_ls, tny_fs, tny_hs, tny_vs, tny_bl},
              {4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});

        // First pix_en after release carries frame_start at the origin
        reset = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            step();
            found = def_pe;
        end
        if (!found) timeout("first_pix_en");
        else check("first_frame_start", {def_fs, def_ls, def_x, def_y}, {1'b1, 1'b1, 10'd0, 10'd0});

        // pix_en cadence: every 2nd clk at DIV=2, every clk at DIV=1
        cnt = 0;
        found = 1'b1;
        for (int c = 0; c < 40; c++) begin
            step();
            cnt += int'(def_pe);
            found &= tny_pe;
        end
        check("pix_en_div2_count", 64'(cnt), 64'd20);
        check("pix_en_div1_always", 64'(found), 64'd1);

        // Position table
        foreach (vecs[i]) begin
            found = 1'b0;
            for (int c = 0; c < 4000 && !found; c++) begin
                step();
                o = get_obs(vecs[i].inst);
                found = (int'(o.x) == vecs[i].x) && (vecs[i].y < 0 || int'(o.y) == vecs[i].y);
            end
            if (!found) timeout($sformatf("vec%0d_position", i));
            else check($sformatf("vec%0d_inst%0d_x%0d_y%0d", i, vecs[i].inst, vecs[i].x, vecs[i].y),
                       {o.hsync, o.vsync, o.blank_b}, {vecs[i].hs, vecs[i].vs, vecs[i].blank});
        end

        // Line period at default timing
        found = 1'b0;
        for (int c = 0; c < 2000 && !found; c++) begin
            step();
            found = def_ls;
        end
        cnt = 0;
        if (found) begin
            found = 1'b0;
            for (int c = 0; c < 2000 && !found; c++) begin
                step();
                cnt++;
                found = def_ls;
            end
        end
        if (!found) timeout("line_period");
        else check("line_period_clks", 64'(cnt), 64'd1600);

        // Reset for one clk mid-line
        found = 1'b0;
        for (int c = 0; c < 2000 && !found; c++) begin
            step();
            found = (def_x == 10'd300) && (def_y != 10'd0);
        end
        if (!found) timeout("reach_x300");
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midreset_state", {def_x, def_y, def_hs, def_bl, def_pe}, {10'd0, 10'd0, 1'b1, 1'b0, 1'b0});
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            step();
            found = def_pe;
        end
        if (!found) timeout("midreset_pix_en");
        else check("midreset_frame_start", {def_fs, def_x, def_y}, {1'b1, 10'd0, 10'd0});

        // Tiny raster: x wraps 11 -> 0 with pix_en still high
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            step();
            found = (tny_x == 4'd11);
        end
        if (!found) timeout("tiny_x11");
        step();
        check("tiny_wrap", {tny_x, tny_pe, tny_ls}, {4'd0, 1'b1, 1'b1});

`ifdef VGA_FRAME_CNT_EN
        // Completed-frame counter: 0 on the first frame_start, wraps at the 17th
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            found = 1'b0;
            for (int c = 0; c < 200 && !found; c++) begin
                step();
                found = tny_fs;
            end
            if (!found) timeout($sformatf("frame_start_%0d", i));
            else check($sformatf("frame_cnt_at_fs%0d", i), 64'(tny_fc), 64'((i - 1) % 16));
        end
`endif

        // Random reset pulses against the model
        for (int c = 0; c < 20000; c++) begin
            if ($urandom_range(0, 1999) == 0) begin
                reset = 1'b1;
                repeat ($urandom_range(1, 3)) step();
                reset = 1'b0;
            end else begin
                step();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
